lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 36 +++
 rtl/lsu.sv | 168 ++++++++++++++++
 tb/tb_lsu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memsize encodings, FSM states
// and helpers for request legality and wait-counter sizing.
package lsu_pkg;

  localparam logic [2:0] MEMSIZE_B  = 3'b000;
  localparam logic [2:0] MEMSIZE_H  = 3'b001;
  localparam logic [2:0] MEMSIZE_W  = 3'b010;
  localparam logic [2:0] MEMSIZE_BU = 3'b100;
  localparam logic [2:0] MEMSIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } lsu_state_e;

  // The counter only has to reach TIMEOUT-1 before the beat is abandoned.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic logic size_legal(input logic we, input logic [2:0] size);
    logic ok;
    case (size)
      MEMSIZE_B, MEMSIZE_H, MEMSIZE_W: ok = 1'b1;
      MEMSIZE_BU, MEMSIZE_HU:          ok = !we;
      default:                         ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic size_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    case (size[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables and write data over an 8-byte
// window (two words), plus load extraction from a merged two-word read.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [63:0] rword,
  output logic [7:0]  be,
  output logic [63:0] wlanes,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [31:0] rlow;

  always_comb begin
    case (size[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    be     = {4'b0000, mask} << offset;
    wlanes = {32'h0, wdata} << {offset, 3'b000};
    rlow   = 32'(rword >> {offset, 3'b000});
    case (size)
      MEMSIZE_B:  rdata = {{24{rlow[7]}}, rlow[7:0]};
      MEMSIZE_H:  rdata = {{16{rlow[15]}}, rlow[15:0]};
      MEMSIZE_BU: rdata = {24'h0, rlow[7:0]};
      MEMSIZE_HU: rdata = {16'h0, rlow[15:0]};
      default:    rdata = rlow;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, single- or split-beat bus access
// with per-beat timeout. Define LSU_MISALIGN_EN to allow misaligned accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e    state, state_n;
  logic          we_q;
  logic [2:0]    size_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          beat_q;
  logic [CW-1:0] cnt;
  logic [31:0]   rlo;

  logic          cnt_clr, cnt_inc, beat_set, lo_cap, load_done, err_set;
  logic          split, req_bad;
  logic [7:0]    be8;
  logic [63:0]   wlanes;
  logic [31:0]   load_data;
  logic [63:0]   rword;

  assign rword = beat_q ? {mem_rdata, rlo} : {32'h0, mem_rdata};

  lsu_align u_align (
    .size   (size_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .rword  (rword),
    .be     (be8),
    .wlanes (wlanes),
    .rdata  (load_data)
  );

`ifdef LSU_MISALIGN_EN
  assign split   = |be8[7:4];
  assign req_bad = !size_legal(req_we, req_size);
`else
  assign split   = 1'b0;
  assign req_bad = !size_legal(req_we, req_size) || size_misaligned(req_size, req_addr[1:0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    beat_set  = 1'b0;
    lo_cap    = 1'b0;
    load_done = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_n = RESP;
            err_set = 1'b1;
          end else begin
            state_n = ISSUE;
            cnt_clr = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          cnt_clr = 1'b1;
          if (!we_q)                 state_n  = WAIT_R;
          else if (split && !beat_q) beat_set = 1'b1;
          else                       state_n  = RESP;
        end else if (cnt == CNT_LAST) begin
          state_n = RESP;
          err_set = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_R: begin
        // First half of a split load is parked in rlo until the second word arrives.
        if (mem_rvalid) begin
          if (split && !beat_q) begin
            state_n  = ISSUE;
            beat_set = 1'b1;
            lo_cap   = 1'b1;
            cnt_clr  = 1'b1;
          end else begin
            state_n   = RESP;
            load_done = 1'b1;
          end
        end else if (cnt == CNT_LAST) begin
          state_n = RESP;
          err_set = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      size_q    <= 3'b000;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      beat_q    <= 1'b0;
      cnt       <= '0;
      rlo       <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q      <= req_we;
        size_q    <= req_size;
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        beat_q    <= 1'b0;
        rsp_rdata <= 32'h0;
        rsp_err   <= 1'b0;
      end
      if (beat_set)  beat_q    <= 1'b1;
      if (lo_cap)    rlo       <= mem_rdata;
      if (cnt_clr)   cnt       <= '0;
      else if (cnt_inc) cnt    <= cnt + 1'b1;
      if (load_done) rsp_rdata <= load_data;
      if (err_set)   rsp_err   <= 1'b1;
    end
  end

  assign req_ready = (state == IDLE) && rst_n;
  assign rsp_valid = (state == RESP);
  assign mem_valid = (state == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2] + {29'h0, beat_q}, 2'b00};
  assign mem_be    = beat_q ? be8[7:4] : be8[3:0];
  assign mem_wdata = beat_q ? wlanes[63:32] : wlanes[31:0];

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU: a scoreboard queue holds the expected response
// of each request; the bench plays the memory side with scripted beats.
module tb_lsu;
  import lsu_pkg::*;

  localparam int TO = 64;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one request for exactly one accepted cycle; returns at the negedge after acceptance.
  task automatic applyStimulus(input logic we, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input logic exp_err);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    sb.push_back('{exp_rdata, exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_size  = 3'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic serveBeat(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] rd, input int delay);
    checkValue("mem_valid", mem_valid, 1);
    checkValue("mem_addr", mem_addr, a);
    checkValue("mem_we", mem_we, we);
    checkValue("mem_be", mem_be, be);
    if (we) checkValue("mem_wdata", mem_wdata, wd);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkValue("mem_hold_valid", mem_valid, 1);
      checkValue("mem_hold_addr", mem_addr, a);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    if (!we) begin
      checkValue("mem_valid_after_read_accept", mem_valid, 0);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
  endtask

  task automatic checkOutput();
    int   n = 0;
    rsp_t exp;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkValue("rsp_valid_seen", rsp_valid, 1);
    if (sb.size() == 0) begin
      checkValue("scoreboard_nonempty", 0, 1);
    end else begin
      exp = sb.pop_front();
      checkValue("rsp_rdata", rsp_rdata, exp.rdata);
      checkValue("rsp_err", rsp_err, exp.err);
    end
    @(negedge clk);
    checkValue("rsp_valid_one_cycle", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1 rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    checkValue("reset_req_ready", req_ready, 0);
    checkValue("reset_mem_valid", mem_valid, 0);
    checkValue("reset_rsp_valid", rsp_valid, 0);
    checkValue("reset_rsp_err", rsp_err, 0);
    checkValue("reset_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;
    #1 checkValue("release_req_ready", req_ready, 1);

    // Loads with sign/zero extension
    applyStimulus(0, MEMSIZE_B, 32'h1003, 0, 32'hFFFFFF80, 0);
    serveBeat(32'h1000, 0, 4'b1000, 0, 32'h80FFFFFF, 0);
    checkOutput();
    applyStimulus(0, MEMSIZE_BU, 32'h1001, 0, 32'h00000080, 0);
    serveBeat(32'h1000, 0, 4'b0010, 0, 32'h00008000, 0);
    checkOutput();
    applyStimulus(0, MEMSIZE_H, 32'h1002, 0, 32'hFFFF8001, 0);
    serveBeat(32'h1000, 0, 4'b1100, 0, 32'h80010000, 1);
    checkOutput();
    applyStimulus(0, MEMSIZE_HU, 32'h1002, 0, 32'h00008001, 0);
    serveBeat(32'h1000, 0, 4'b1100, 0, 32'h80010000, 0);
    checkOutput();
    applyStimulus(0, MEMSIZE_W, 32'h1008, 0, 32'hCAFEF00D, 0);
    serveBeat(32'h1008, 0, 4'b1111, 0, 32'hCAFEF00D, 3);
    checkOutput();

    // Stores: lane steering, rdata is zero
    applyStimulus(1, MEMSIZE_H, 32'h2002, 32'h0000BEEF, 0, 0);
    serveBeat(32'h2000, 1, 4'b1100, 32'hBEEF0000, 0, 0);
    checkOutput();
    applyStimulus(1, MEMSIZE_B, 32'h5001, 32'h123456AB, 0, 0);
    serveBeat(32'h5000, 1, 4'b0010, 32'h3456AB00, 0, 2);
    checkOutput();
    applyStimulus(1, MEMSIZE_W, 32'h5004, 32'hDEADBEEF, 0, 0);
    serveBeat(32'h5004, 1, 4'b1111, 32'hDEADBEEF, 0, 0);
    checkOutput();

    // Illegal sizes respond one cycle after acceptance without a bus beat
    applyStimulus(0, 3'b011, 32'h1000, 0, 0, 1);
    checkValue("illegal_load_rsp_latency", rsp_valid, 1);
    checkValue("illegal_load_no_beat", mem_valid, 0);
    checkOutput();
    applyStimulus(1, MEMSIZE_BU, 32'h1000, 32'h11, 0, 1);
    checkValue("illegal_store_rsp_latency", rsp_valid, 1);
    checkValue("illegal_store_no_beat", mem_valid, 0);
    checkOutput();

    // Timeout with mem_ready held low
    applyStimulus(0, MEMSIZE_W, 32'h3000, 0, 0, 1);
    n = 0;
    while (mem_valid && n < TO + 10) begin
      @(negedge clk);
      n++;
    end
    checkValue("timeout_issue_cycles", n, TO);
    checkValue("timeout_mem_valid_dropped", mem_valid, 0);
    checkOutput();
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    checkValue("late_rvalid_ignored", seen, 0);

    // Misaligned accesses
`ifdef LSU_MISALIGN_EN
    applyStimulus(0, MEMSIZE_W, 32'h4002, 0, 32'h11223344, 0);
    serveBeat(32'h4000, 0, 4'b1100, 0, 32'h3344AAAA, 0);
    serveBeat(32'h4004, 0, 4'b0011, 0, 32'hBBBB1122, 1);
    checkOutput();
    applyStimulus(0, MEMSIZE_H, 32'h4001, 0, 32'hFFFF8877, 0);
    serveBeat(32'h4000, 0, 4'b0110, 0, 32'h00887700, 0);
    checkOutput();
    applyStimulus(1, MEMSIZE_W, 32'h7003, 32'hAABBCCDD, 0, 0);
    serveBeat(32'h7000, 1, 4'b1000, 32'hDD000000, 0, 0);
    serveBeat(32'h7004, 1, 4'b0111, 32'h00AABBCC, 0, 1);
    checkOutput();
`else
    applyStimulus(0, MEMSIZE_W, 32'h4002, 0, 0, 1);
    checkValue("misaligned_word_no_beat", mem_valid, 0);
    checkOutput();
    applyStimulus(1, MEMSIZE_H, 32'h4001, 32'h1234, 0, 1);
    checkValue("misaligned_half_no_beat", mem_valid, 0);
    checkOutput();
`endif

    // Reset during ISSUE
    applyStimulus(0, MEMSIZE_W, 32'h6000, 0, 0, 0);
    void'(sb.pop_back());
    checkValue("issue_before_reset", mem_valid, 1);
    #2 rst_n = 1'b0;
    #1 checkValue("reset_in_issue_mem_valid", mem_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT_R abandons the load
    applyStimulus(0, MEMSIZE_W, 32'h6004, 0, 0, 0);
    void'(sb.pop_back());
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkValue("reset_in_wait_mem_valid", mem_valid, 0);
    checkValue("reset_in_wait_rsp_valid", rsp_valid, 0);
    checkValue("reset_in_wait_req_ready", req_ready, 0);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    rst_n = 1'b1;
    #1 checkValue("after_reset_idle", req_ready, 1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= rsp_valid | mem_valid;
    end
    checkValue("no_response_after_reset", seen, 0);

    // Unit still operates after the abandoned access
    applyStimulus(0, MEMSIZE_B, 32'h1000, 0, 32'h0000007F, 0);
    serveBeat(32'h1000, 0, 4'b0001, 0, 32'hFFFFFF7F, 0);
    checkOutput();

    checkValue("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
